// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller:
// opcode constants, FSM encoding and the control bundle.
package pipeline_pkg;

   localparam int         OPCODE_W_DEF    = 4;
   localparam int         REG_W_DEF       = 3;
   localparam logic [3:0] OP_LOAD_DEF     = 4'd0;
   localparam logic [3:0] OP_STORE_DEF    = 4'd1;
   localparam int         MEM_TIMEOUT_DEF = 15;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_e;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic memwb_en;
      logic ifid_flush;
      logic idex_flush;
      logic memwb_flush;
   } ctrl_t;

   function automatic ctrl_t ctrl_flow();
      ctrl_t c;
      c             = '0;
      c.pc_en       = 1'b1;
      c.ifid_en     = 1'b1;
      c.idex_en     = 1'b1;
      c.exmem_en    = 1'b1;
      c.memwb_en    = 1'b1;
      return c;
   endfunction

   // Whole pipe held; a bubble is pushed into WB.
   function automatic ctrl_t ctrl_freeze();
      ctrl_t c;
      c             = '0;
      c.memwb_flush = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
// hazard_detect: combinational load-use compare between the
// ID sources and the destination of a load sitting in EX.
// Ports: id_rs1/2, id_use_rs1/2, ex_opcode, ex_rd -> load_use.
module hazard_detect
   import pipeline_pkg::*;
#(
   parameter int                    OPCODE_W = OPCODE_W_DEF,
   parameter int                    REG_W    = REG_W_DEF,
   parameter logic [OPCODE_W-1:0]   OP_LOAD  = OPCODE_W'(OP_LOAD_DEF)
) (
   input  logic [REG_W-1:0]    id_rs1,
   input  logic [REG_W-1:0]    id_rs2,
   input  logic                id_use_rs1,
   input  logic                id_use_rs2,
   input  logic [OPCODE_W-1:0] ex_opcode,
   input  logic [REG_W-1:0]    ex_rd,
   output logic                load_use
);

   logic hit1;
   logic hit2;

   always_comb begin
      hit1     = id_use_rs1 && (id_rs1 == ex_rd);
      hit2     = id_use_rs2 && (id_rs2 == ex_rd);
      load_use = (ex_opcode == OP_LOAD) && (hit1 || hit2);
   end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use,
// branch squash, multi-cycle data memory with timeout.
// Ports: clock/reset, ID/EX/MEM observation inputs, mem_ack;
// register enables/flushes, mem_req, mem_error, stall_count.
module pipeline_hazard_controller
   import pipeline_pkg::*;
#(
   parameter int                  OPCODE_W    = OPCODE_W_DEF,
   parameter int                  REG_W       = REG_W_DEF,
   parameter logic [OPCODE_W-1:0] OP_LOAD     = OPCODE_W'(OP_LOAD_DEF),
   parameter logic [OPCODE_W-1:0] OP_STORE    = OPCODE_W'(OP_STORE_DEF),
   parameter int                  MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [REG_W-1:0]    id_rs1,
   input  logic [REG_W-1:0]    id_rs2,
   input  logic                id_use_rs1,
   input  logic                id_use_rs2,
   input  logic [OPCODE_W-1:0] ex_opcode,
   input  logic [REG_W-1:0]    ex_rd,
   input  logic                branch_taken,
   input  logic [OPCODE_W-1:0] mem_opcode,
   input  logic                mem_ack,
   output logic                pc_en,
   output logic                ifid_en,
   output logic                idex_en,
   output logic                exmem_en,
   output logic                memwb_en,
   output logic                ifid_flush,
   output logic                idex_flush,
   output logic                memwb_flush,
   output logic                mem_req,
   output logic                mem_error,
   output logic [15:0]         stall_count
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             mem_error_q, mem_error_d;
   logic [15:0]      stall_count_q, stall_count_d;

   logic  load_use;
   logic  is_mem;
   logic  req;
   ctrl_t rel;
   ctrl_t ctrl;

   hazard_detect #(
      .OPCODE_W (OPCODE_W),
      .REG_W    (REG_W),
      .OP_LOAD  (OP_LOAD)
   ) u_hazard (
      .id_rs1     (id_rs1),
      .id_rs2     (id_rs2),
      .id_use_rs1 (id_use_rs1),
      .id_use_rs2 (id_use_rs2),
      .ex_opcode  (ex_opcode),
      .ex_rd      (ex_rd),
      .load_use   (load_use)
   );

   always_comb begin
      is_mem = (mem_opcode == OP_LOAD) || (mem_opcode == OP_STORE);

      // Normal-flow decode; also used on the cycle a memory stall
      // ends, so a branch/load-use held in EX is acted on then.
      rel = ctrl_flow();
      if (branch_taken) begin
         rel.ifid_flush = 1'b1;
         rel.idex_flush = 1'b1;
      end else if (load_use) begin
         rel.pc_en      = 1'b0;
         rel.ifid_en    = 1'b0;
         rel.idex_flush = 1'b1;
      end

      ctrl          = rel;
      req           = 1'b0;
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_error_d   = mem_error_q;

      unique case (state_q)
         RUN: begin
            if (is_mem) begin
               req = 1'b1;
               if (!mem_ack) begin
                  ctrl       = ctrl_freeze();
                  state_d    = MEM_WAIT;
                  wait_cnt_d = CNT_W'(1);
               end
            end
         end
         MEM_WAIT: begin
            if (mem_ack) begin
               req        = 1'b1;
               state_d    = RUN;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT)) begin
               // Access abandoned: let the pipe move on and
               // keep the missing result out of WB.
               ctrl.memwb_flush = 1'b1;
               mem_error_d      = 1'b1;
               state_d          = RUN;
               wait_cnt_d       = '0;
            end else begin
               req        = 1'b1;
               ctrl       = ctrl_freeze();
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase

      stall_count_d = stall_count_q;
      if (!ctrl.pc_en && (stall_count_q != 16'hFFFF)) begin
         stall_count_d = stall_count_q + 16'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= RUN;
         wait_cnt_q    <= '0;
         mem_error_q   <= 1'b0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_error_q   <= mem_error_d;
         stall_count_q <= stall_count_d;
      end
   end

   // Reset forces every register open and flushed, no request.
   always_comb begin
      if (reset) begin
         pc_en       = 1'b1;
         ifid_en     = 1'b1;
         idex_en     = 1'b1;
         exmem_en    = 1'b1;
         memwb_en    = 1'b1;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         memwb_flush = 1'b1;
         mem_req     = 1'b0;
      end else begin
         pc_en       = ctrl.pc_en;
         ifid_en     = ctrl.ifid_en;
         idex_en     = ctrl.idex_en;
         exmem_en    = ctrl.exmem_en;
         memwb_en    = ctrl.memwb_en;
         ifid_flush  = ctrl.ifid_flush;
         idex_flush  = ctrl.idex_flush;
         memwb_flush = ctrl.memwb_flush;
         mem_req     = req;
      end
      mem_error   = mem_error_q;
      stall_count = stall_count_q;
   end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: vector table
// for single-cycle decode plus multi-cycle memory sequences.
module tb_pipeline_hazard_controller;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] id_rs1 = '0;
   logic [2:0] id_rs2 = '0;
   logic       id_use_rs1 = 1'b0;
   logic       id_use_rs2 = 1'b0;
   logic [3:0] ex_opcode = 4'd5;
   logic [2:0] ex_rd = '0;
   logic       branch_taken = 1'b0;
   logic [3:0] mem_opcode = 4'd7;
   logic       mem_ack = 1'b0;
   logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic       ifid_flush, idex_flush, memwb_flush;
   logic       mem_req, mem_error;
   logic [15:0] stall_count;

   int total = 0;
   int bad   = 0;

   // {pc,ifid,idex,exmem,memwb, ifid_f,idex_f,memwb_f, req}
   localparam logic [8:0] E_NORM  = 9'b11111_000_0;
   localparam logic [8:0] E_LU    = 9'b00111_010_0;
   localparam logic [8:0] E_BR    = 9'b11111_110_0;
   localparam logic [8:0] E_FRZ   = 9'b00000_001_1;
   localparam logic [8:0] E_ACK   = 9'b11111_000_1;
   localparam logic [8:0] E_ACKBR = 9'b11111_110_1;
   localparam logic [8:0] E_ABORT = 9'b11111_001_0;
   localparam logic [8:0] E_RST   = 9'b11111_111_0;

   wire [8:0] outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                      ifid_flush, idex_flush, memwb_flush, mem_req};

   typedef struct {
      logic [2:0] rs1;
      logic [2:0] rs2;
      logic       u1;
      logic       u2;
      logic [3:0] exop;
      logic [2:0] exrd;
      logic       br;
      logic [3:0] memop;
      logic       ack;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[10];

   pipeline_hazard_controller dut (
      .clock        (clock),
      .reset        (reset),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_use_rs1   (id_use_rs1),
      .id_use_rs2   (id_use_rs2),
      .ex_opcode    (ex_opcode),
      .ex_rd        (ex_rd),
      .branch_taken (branch_taken),
      .mem_opcode   (mem_opcode),
      .mem_ack      (mem_ack),
      .pc_en        (pc_en),
      .ifid_en      (ifid_en),
      .idex_en      (idex_en),
      .exmem_en     (exmem_en),
      .memwb_en     (memwb_en),
      .ifid_flush   (ifid_flush),
      .idex_flush   (idex_flush),
      .memwb_flush  (memwb_flush),
      .mem_req      (mem_req),
      .mem_error    (mem_error),
      .stall_count  (stall_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic set_idle();
      id_rs1 = 3'd0; id_rs2 = 3'd0;
      id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_opcode = 4'd5; ex_rd = 3'd0;
      branch_taken = 1'b0;
      mem_opcode = 4'd7; mem_ack = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      set_idle();
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      id_rs1 = v.rs1; id_rs2 = v.rs2;
      id_use_rs1 = v.u1; id_use_rs2 = v.u2;
      ex_opcode = v.exop; ex_rd = v.exrd;
      branch_taken = v.br;
      mem_opcode = v.memop; mem_ack = v.ack;
   endtask

   initial begin
      vecs[0] = '{3'd0, 3'd0, 1'b0, 1'b0, 4'd5, 3'd0, 1'b0, 4'd7, 1'b0, E_NORM};
      vecs[1] = '{3'd3, 3'd0, 1'b1, 1'b0, 4'd0, 3'd3, 1'b0, 4'd7, 1'b0, E_LU};
      vecs[2] = '{3'd3, 3'd0, 1'b0, 1'b0, 4'd0, 3'd3, 1'b0, 4'd7, 1'b0, E_NORM};
      vecs[3] = '{3'd1, 3'd6, 1'b1, 1'b1, 4'd0, 3'd6, 1'b0, 4'd7, 1'b0, E_LU};
      vecs[4] = '{3'd2, 3'd0, 1'b1, 1'b0, 4'd1, 3'd2, 1'b0, 4'd7, 1'b0, E_NORM};
      vecs[5] = '{3'd0, 3'd0, 1'b0, 1'b0, 4'd5, 3'd0, 1'b1, 4'd7, 1'b0, E_BR};
      vecs[6] = '{3'd4, 3'd0, 1'b1, 1'b0, 4'd0, 3'd4, 1'b1, 4'd7, 1'b0, E_BR};
      vecs[7] = '{3'd0, 3'd0, 1'b0, 1'b0, 4'd5, 3'd0, 1'b0, 4'd0, 1'b1, E_ACK};
      vecs[8] = '{3'd5, 3'd5, 1'b0, 1'b1, 4'd0, 3'd5, 1'b0, 4'd1, 1'b1, E_LU | 9'b1};
      vecs[9] = '{3'd1, 3'd7, 1'b1, 1'b0, 4'd0, 3'd7, 1'b0, 4'd7, 1'b0, E_NORM};

      // Reset state
      #1;
      chk("reset_outs", outs, E_RST);
      chk("reset_stall", stall_count, 0);
      chk("reset_err", mem_error, 0);
      @(negedge clock);
      reset = 1'b0;

      // Decode table, no memory stalls
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         apply(vecs[i]);
         #1;
         chk($sformatf("vec%0d", i), outs, vecs[i].exp);
      end
      @(negedge clock);
      set_idle();
      #1;
      chk("table_stalls", stall_count, 3);

      // Load-use single bubble
      do_reset();
      ex_opcode = 4'd0; ex_rd = 3'd3; id_rs1 = 3'd3; id_use_rs1 = 1'b1;
      #1;
      chk("lu_bubble", outs, E_LU);
      @(negedge clock);
      ex_opcode = 4'd5;
      #1;
      chk("lu_next", outs, E_NORM);
      chk("lu_stall", stall_count, 1);

      // Memory wait, ack on 4th cycle
      do_reset();
      mem_opcode = 4'd0;
      for (int c = 1; c <= 3; c++) begin
         #1;
         chk($sformatf("mw_frz%0d", c), outs, E_FRZ);
         @(negedge clock);
      end
      mem_ack = 1'b1;
      #1;
      chk("mw_ack", outs, E_ACK);
      @(negedge clock);
      set_idle();
      #1;
      chk("mw_after", outs, E_NORM);
      chk("mw_stall", stall_count, 3);

      // Branch during memory wait is held until ack
      do_reset();
      mem_opcode = 4'd0; branch_taken = 1'b1;
      for (int c = 1; c <= 2; c++) begin
         #1;
         chk($sformatf("brw_frz%0d", c), outs, E_FRZ);
         @(negedge clock);
      end
      mem_ack = 1'b1;
      #1;
      chk("brw_ack", outs, E_ACKBR);

      // Timeout: 15 frozen cycles, abort on the 16th
      do_reset();
      mem_opcode = 4'd1;
      for (int c = 1; c <= 15; c++) begin
         #1;
         chk($sformatf("to_frz%0d", c), outs, E_FRZ);
         @(negedge clock);
      end
      #1;
      chk("to_abort", outs, E_ABORT);
      chk("to_err_pre", mem_error, 0);
      @(negedge clock);
      mem_opcode = 4'd7;
      #1;
      chk("to_err", mem_error, 1);
      chk("to_run", outs, E_NORM);
      chk("to_stall", stall_count, 15);
      @(negedge clock);
      #1;
      chk("to_sticky", mem_error, 1);

      // Async reset in the middle of a memory wait
      @(negedge clock);
      mem_opcode = 4'd0;
      @(negedge clock);
      #1;
      chk("rw_frz", outs, E_FRZ);
      #1;
      reset = 1'b1;
      #1;
      chk("rw_outs", outs, E_RST);
      chk("rw_err", mem_error, 0);
      chk("rw_stall", stall_count, 0);
      @(negedge clock);
      reset = 1'b0;
      mem_opcode = 4'd7;
      #1;
      chk("rw_run", outs, E_NORM);

      // Stall counter saturation
      do_reset();
      ex_opcode = 4'd0; ex_rd = 3'd2; id_rs2 = 3'd2; id_use_rs2 = 1'b1;
      repeat (65534) @(posedge clock);
      @(negedge clock);
      #1;
      chk("sat_fffe", stall_count, 16'hFFFE);
      repeat (6) @(posedge clock);
      @(negedge clock);
      #1;
      chk("sat_ffff", stall_count, 16'hFFFF);
      chk("sat_stall", outs, E_LU);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
